// File: rtl/instr_encoder_loader.sv
// Packs decoded instruction fields into 32-bit MIPS words and streams them into imem from address 0.
// Latency: one cycle from accepted bundle to imem write. Backpressure: in_ready is high only while loading and below DEPTH.
// Optional feature INSTR_PAD_EN: fill the unused tail of imem with NOPs before finishing.
module instr_encoder_loader #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [2:0]        in_kind,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [5:0]        in_func,
    input  logic [15:0]       in_imm,
    input  logic [25:0]       in_target,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_PAD,
        S_FIN
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] wordCnt;
    logic [CNT_W-1:0] cntNext;
    logic [31:0]      encWord;
    logic             encLegal;
    logic             lastWord;

    always_comb begin
        encWord  = 32'h0;
        encLegal = 1'b1;
        case (in_kind)
            3'd0:    encWord = {6'b000000, in_rs, in_rt, in_rd, in_shamt, in_func};
            3'd1:    encWord = {6'b100011, in_rs, in_rt, in_imm};
            3'd2:    encWord = {6'b101011, in_rs, in_rt, in_imm};
            3'd3:    encWord = {6'b000101, in_rs, in_rt, in_imm};
            3'd4:    encWord = {6'b000010, in_target};
            default: encLegal = 1'b0;
        endcase
    end

    assign cntNext  = wordCnt + 1'b1;
    // The DEPTH-th word closes the session even without in_last.
    assign lastWord = in_last || (cntNext == DEPTH_C);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            wordCnt    <= '0;
            in_ready   <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= 32'h0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            imem_we <= 1'b0;
            done    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        wordCnt  <= '0;
                        err      <= 1'b0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (in_valid && in_ready) begin
                        imem_we    <= 1'b1;
                        imem_addr  <= ADDR_W'(wordCnt);
                        imem_wdata <= encLegal ? encWord : 32'h0;
                        wordCnt    <= cntNext;
                        if (!encLegal) err <= 1'b1;
                        if (lastWord) begin
                            in_ready <= 1'b0;
`ifdef INSTR_PAD_EN
                            if (cntNext != DEPTH_C) begin
                                state <= S_PAD;
                            end else begin
                                busy  <= 1'b0;
                                done  <= 1'b1;
                                state <= S_FIN;
                            end
`else
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_FIN;
`endif
                        end
                    end
                end
                S_PAD: begin
                    imem_we    <= 1'b1;
                    imem_addr  <= ADDR_W'(wordCnt);
                    imem_wdata <= 32'h0;
                    wordCnt    <= cntNext;
                    if (cntNext == DEPTH_C) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_FIN;
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Bench for instr_encoder_loader: table vectors, randomized sessions against a field-rule model, reset corner cases.
module tb_instr_encoder_loader;

    localparam int ADDR_W = 4;
    localparam int DEPTH  = 8;
`ifdef INSTR_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n, start, in_valid, in_last;
    logic              in_ready;
    logic [2:0]        in_kind;
    logic [4:0]        in_rs, in_rt, in_rd, in_shamt;
    logic [5:0]        in_func;
    logic [15:0]       in_imm;
    logic [25:0]       in_target;
    logic              imem_we, busy, done, err;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    instr_encoder_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_last(in_last), .in_kind(in_kind), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_shamt(in_shamt), .in_func(in_func), .in_imm(in_imm), .in_target(in_target),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  kind;
        logic [4:0]  rs, rt, rd, sh;
        logic [5:0]  fn;
        logic [15:0] imm;
        logic [25:0] tgt;
        logic [31:0] exp;
    } vec_t;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int xferC[$];
    int wCyc[$];
    int doneC[$];
    logic [31:0] wAddr[$];
    logic [31:0] wData[$];
    vec_t sess[$];
    vec_t tbl[7];

    always @(posedge clk) begin
        if (rst_n && in_valid && in_ready) xferC.push_back(cyc);
        cyc = cyc + 1;
    end

    always @(negedge clk) begin
        if (imem_we) begin
            wAddr.push_back(32'(imem_addr));
            wData.push_back(imem_wdata);
            wCyc.push_back(cyc);
        end
        if (done) doneC.push_back(cyc);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Opcode placement by plain arithmetic on field positions.
    function automatic logic [31:0] model_enc(vec_t v);
        case (v.kind)
            3'd0: return (32'(v.rs) << 21) + (32'(v.rt) << 16) + (32'(v.rd) << 11) + (32'(v.sh) << 6) + 32'(v.fn);
            3'd1: return (32'd35 << 26) + (32'(v.rs) << 21) + (32'(v.rt) << 16) + 32'(v.imm);
            3'd2: return (32'd43 << 26) + (32'(v.rs) << 21) + (32'(v.rt) << 16) + 32'(v.imm);
            3'd3: return (32'd5 << 26) + (32'(v.rs) << 21) + (32'(v.rt) << 16) + 32'(v.imm);
            3'd4: return (32'd2 << 26) + 32'(v.tgt);
            default: return 32'h0;
        endcase
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        v.kind = 3'($urandom_range(0, 7));
        v.rs = 5'($urandom); v.rt = 5'($urandom); v.rd = 5'($urandom); v.sh = 5'($urandom);
        v.fn = 6'($urandom); v.imm = 16'($urandom); v.tgt = 26'($urandom);
        v.exp = 32'h0;
        return v;
    endfunction

    task automatic drive_vec(input vec_t v, input logic last);
        in_kind = v.kind; in_rs = v.rs; in_rt = v.rt; in_rd = v.rd; in_shamt = v.sh;
        in_func = v.fn; in_imm = v.imm; in_target = v.tgt; in_last = last;
    endtask

    task automatic clear_logs();
        xferC.delete(); wCyc.delete(); doneC.delete(); wAddr.delete(); wData.delete();
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ready"}, 32'(in_ready), 0);
        check({tag, "_we"}, 32'(imem_we), 0);
        check({tag, "_addr"}, 32'(imem_addr), 0);
        check({tag, "_wdata"}, imem_wdata, 0);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_err"}, 32'(err), 0);
    endtask

    // Runs one session over sess[] and compares the write stream to the model.
    task automatic run_session(input string tag, input int gap);
        int t;
        bit ended;
        int nAcc;
        bit expErr;
        logic [31:0] eData[$];
        clear_logs();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check({tag, "_err_clr"}, 32'(err), 0);
        check({tag, "_busy_on"}, 32'(busy), 1);
        ended = 1'b0;
        for (int i = 0; i < sess.size() && !ended; i++) begin
            drive_vec(sess[i], i == sess.size() - 1);
            if ($urandom_range(0, 99) < gap) begin
                in_valid = 1'b0;
                @(negedge clk);
            end
            in_valid = 1'b1;
            t = 0;
            while (1) begin
                if (in_ready) begin
                    @(negedge clk);
                    break;
                end
                if (!busy) begin
                    ended = 1'b1;
                    break;
                end
                if (t > 20) begin
                    check({tag, "_ready_timeout"}, 1, 0);
                    ended = 1'b1;
                    break;
                end
                @(negedge clk);
                t++;
            end
        end
        in_valid = 1'b0;
        in_last = 1'b0;
        t = 0;
        while (busy && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (busy) check({tag, "_busy_timeout"}, 1, 0);
        repeat (3) @(negedge clk);

        nAcc = 0;
        expErr = 1'b0;
        for (int i = 0; i < sess.size(); i++) begin
            nAcc++;
            eData.push_back(model_enc(sess[i]));
            if (sess[i].kind > 3'd4) expErr = 1'b1;
            if (i == sess.size() - 1 || nAcc == DEPTH) break;
        end
        if (PAD) while (eData.size() < DEPTH) eData.push_back(32'h0);

        check({tag, "_nxfer"}, 32'(xferC.size()), 32'(nAcc));
        check({tag, "_nwrites"}, 32'(wData.size()), 32'(eData.size()));
        for (int i = 0; i < wData.size() && i < eData.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), wAddr[i], 32'(i));
            check($sformatf("%s_data%0d", tag, i), wData[i], eData[i]);
            if (i < nAcc && i < xferC.size())
                check($sformatf("%s_lat%0d", tag, i), 32'(wCyc[i]), 32'(xferC[i] + 1));
            else if (i >= nAcc && i > 0)
                check($sformatf("%s_pad_cyc%0d", tag, i), 32'(wCyc[i]), 32'(wCyc[i - 1] + 1));
        end
        check({tag, "_ndone"}, 32'(doneC.size()), 1);
        if (doneC.size() == 1 && wCyc.size() > 0)
            check({tag, "_done_cyc"}, 32'(doneC[0]), 32'(wCyc[wCyc.size() - 1]));
        check({tag, "_err"}, 32'(err), 32'(expErr));
        check({tag, "_busy_off"}, 32'(busy), 0);
        check({tag, "_ready_off"}, 32'(in_ready), 0);
        check({tag, "_addr_hold"}, 32'(imem_addr), 32'(eData.size() - 1));
        check({tag, "_data_hold"}, imem_wdata, eData[eData.size() - 1]);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
        v = rand_vec();
        drive_vec(v, 1'b0);

        tbl[0] = '{3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100000, 16'hBEEF, 26'h3ABCDEF, 32'h00221820};
        tbl[1] = '{3'd0, 5'd0, 5'd1, 5'd2, 5'd3, 6'b000000, 16'h1234, 26'h1555555, 32'h000110C0};
        tbl[2] = '{3'd6, 5'd7, 5'd7, 5'd7, 5'd7, 6'h3F,     16'hFFFF, 26'h3FFFFFF, 32'h00000000};
        tbl[3] = '{3'd1, 5'd1, 5'd2, 5'd31, 5'd31, 6'h3F,   16'h0004, 26'h2AAAAAA, 32'h8C220004};
        tbl[4] = '{3'd2, 5'd1, 5'd2, 5'd9, 5'd9, 6'h15,     16'h0008, 26'h0000001, 32'hAC220008};
        tbl[5] = '{3'd3, 5'd1, 5'd2, 5'd0, 5'd0, 6'h00,     16'hFFFF, 26'h0F0F0F0, 32'h1422FFFF};
        tbl[6] = '{3'd4, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h0000010, 32'h08000010};

        repeat (3) @(negedge clk);
        check_outputs_zero("rst");
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_ready", 32'(in_ready), 0);

        sess.delete();
        foreach (tbl[i]) sess.push_back(tbl[i]);
        run_session("tbl", 0);
        for (int i = 0; i < 7 && i < wData.size(); i++) begin
            check($sformatf("tbl_const%0d", i), wData[i], tbl[i].exp);
            check($sformatf("tbl_b2b%0d", i), 32'(wCyc[i]), 32'(wCyc[0] + i));
        end
        repeat (2) @(negedge clk);
        check("err_sticky", 32'(err), 1);

        sess.delete();
        for (int i = 0; i < 10; i++) begin
            v = rand_vec();
            v.kind = 3'($urandom_range(0, 4));
            sess.push_back(v);
        end
        run_session("sat", 0);

        for (int s = 0; s < 8; s++) begin
            sess.delete();
            for (int i = 0; i < int'($urandom_range(1, 11)); i++) sess.push_back(rand_vec());
            run_session($sformatf("rnd%0d", s), 30);
        end

        // Reset in the middle of a session; a stray start on word 1 must be ignored.
        clear_logs();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            v = rand_vec();
            v.kind = 3'($urandom_range(0, 4));
            drive_vec(v, 1'b0);
            start = (i == 1);
            in_valid = 1'b1;
            @(negedge clk);
        end
        start = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        check_outputs_zero("midrst");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        in_valid = 1'b0;
        check("midrst_nwrites", 32'(wData.size()), 3);
        for (int i = 0; i < 3 && i < wAddr.size(); i++)
            check($sformatf("midrst_addr%0d", i), wAddr[i], 32'(i));
        check("midrst_ndone", 32'(doneC.size()), 0);
        check("midrst_idle_ready", 32'(in_ready), 0);

        sess.delete();
        for (int i = 0; i < 3; i++) sess.push_back(rand_vec());
        run_session("post", 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
